pwm_capture: RTL and testbench

//  Receive side of the servo-style PWM link: measures an incoming PWM wave and recovers
//  the 7-bit duty code (0..99) that the PWM generator encodes as

---
 rtl/pwm_params_pkg.sv | 25 ++
 rtl/pwm_capture_seq_divider.sv | 59 +++++
 rtl/pwm_capture.sv | 191 +++++++++++++++++++
 tb/tb_pwm_capture.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_params_pkg.sv
// Constants shared by the PWM generator and capture ends of the servo-style PWM link.
package pwm_params;

    localparam int unsigned PWM_WINDOW  = 2000000;  // frame length, clk cycles
    localparam int unsigned PWM_OFFSET  = 50000;    // high time for duty code 0
    localparam int unsigned PWM_STEP    = 2000;     // high-time increment per code
    localparam int unsigned PWM_PER_TOL = 20000;    // accepted |period - window|
    localparam int unsigned PWM_TIMEOUT = 4000000;  // edge-free cycles before loss
    localparam int unsigned PWM_CNT_W   = 23;       // counter width, holds TIMEOUT

    localparam int unsigned DUTY_W   = 7;
    localparam int unsigned DUTY_MAX = 99;

    typedef enum logic [1:0] {
        SEEK = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } cap_state_t;

    // Saturate a raw quotient to the largest legal duty code
    function automatic logic [DUTY_W-1:0] clamp_duty(input logic [31:0] q);
        return (q > 32'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : DUTY_W'(q);
    endfunction

endpackage

// File: rtl/pwm_capture_seq_divider.sv
// Restoring sequential divider: W-bit dividend by a constant divisor, one quotient bit per cycle.
// done stays high with the quotient held until the next start or an abort.
module seq_divider #(
    parameter int unsigned W       = 23,
    parameter int unsigned DIVISOR = 2000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned IW  = $clog2(W + 1);
    localparam int unsigned WP1 = W + 1;
    localparam logic [W:0]  DIV_C = WP1'(DIVISOR);

    logic [W-1:0]  rem;
    logic [IW-1:0] iter;
    logic [W:0]    trial;
    logic          fits;

    // Partial remainder with the next dividend bit shifted in
    assign trial = {rem, quotient[W-1]};
    assign fits  = (trial >= DIV_C);

    // Iteration: quotient register doubles as the dividend shift register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem      <= '0;
            quotient <= '0;
            iter     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort) begin
            iter <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            rem      <= '0;
            quotient <= dividend;
            iter     <= IW'(W);
            busy     <= 1'b1;
            done     <= 1'b0;
        end else if (busy) begin
            rem      <= fits ? W'(trial - DIV_C) : W'(trial);
            quotient <= {quotient[W-2:0], fits};
            iter     <= iter - IW'(1);
            if (iter == IW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming servo-style PWM wave and recovers the duty code it carries.
module pwm_capture
    import pwm_params::*;
#(
    parameter int unsigned WINDOW  = PWM_WINDOW,
    parameter int unsigned OFFSET  = PWM_OFFSET,
    parameter int unsigned STEP    = PWM_STEP,
    parameter int unsigned PER_TOL = PWM_PER_TOL,
    parameter int unsigned TIMEOUT = PWM_TIMEOUT,
    parameter int unsigned CNT_W   = PWM_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              valid,
    output logic              period_err,
    output logic              no_signal
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] PER_MIN_C = CNT_W'(WINDOW - PER_TOL);
    localparam logic [CNT_W-1:0] PER_MAX_C = CNT_W'(WINDOW + PER_TOL);
    localparam logic [CNT_W-1:0] OFFSET_C  = CNT_W'(OFFSET);
    localparam logic [CNT_W-1:0] HALF_C    = CNT_W'(STEP / 2);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic              sync_a;
    logic              sync_b;
    logic              sync_d;
    logic              rise;
    logic              fall;

    cap_state_t        state;
    cap_state_t        state_nx;

    logic [CNT_W-1:0]  per_cnt;
    logic [CNT_W-1:0]  hi_cnt;
    logic [CNT_W-1:0]  dividend;
    logic [CNT_W-1:0]  quotient;
    logic              period_ok;
    logic              timed_out;

    logic              frame_start;
    logic              div_start;
    logic              div_abort;
    logic              div_busy;
    logic              div_done;

    logic [DUTY_W-1:0] duty_nx;
    logic              valid_nx;
    logic              period_err_nx;
    logic              no_signal_nx;

    // Two-stage synchroniser plus edge delay; resets high so a pulse already in
    // progress at reset release is not mistaken for a rising edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            sync_d <= 1'b1;
        end else begin
            sync_a <= pwm_in;
            sync_b <= sync_a;
            sync_d <= sync_b;
        end
    end

    assign rise      = sync_b & ~sync_d;
    assign fall      = ~sync_b & sync_d;
    assign period_ok = (per_cnt >= PER_MIN_C) && (per_cnt <= PER_MAX_C);
    assign timed_out = (per_cnt >= TIMEOUT_C);

    // Rise-to-rise period and rise-to-fall high time; both restart at 1 on the
    // opening rise so each holds an exact cycle count on its closing edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (state_nx == SEEK) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (frame_start) begin
            per_cnt <= ONE_C;
            hi_cnt  <= ONE_C;
        end else begin
            if (per_cnt != TIMEOUT_C) begin
                per_cnt <= per_cnt + ONE_C;
            end
            if ((state == HIGH) && (hi_cnt != TIMEOUT_C)) begin
                hi_cnt <= hi_cnt + ONE_C;
            end
        end
    end

    // Offset-removed high time with half a step added so floor division rounds to nearest
    always_comb begin
        dividend = '0;
        if (hi_cnt >= OFFSET_C) begin
            dividend = hi_cnt - OFFSET_C + HALF_C;
        end
    end

    seq_divider #(
        .W       (CNT_W),
        .DIVISOR (STEP)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (dividend),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quotient)
    );

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SEEK;
            duty_cycle <= '0;
            valid      <= 1'b0;
            period_err <= 1'b0;
            no_signal  <= 1'b1;
        end else begin
            state      <= state_nx;
            duty_cycle <= duty_nx;
            valid      <= valid_nx;
            period_err <= period_err_nx;
            no_signal  <= no_signal_nx;
        end
    end

    // Next state, frame accept/reject and divider control
    always_comb begin
        state_nx      = state;
        frame_start   = 1'b0;
        div_start     = 1'b0;
        div_abort     = 1'b0;
        duty_nx       = duty_cycle;
        valid_nx      = 1'b0;
        period_err_nx = 1'b0;
        no_signal_nx  = no_signal;

        case (state)
            SEEK: begin
                if (rise) begin
                    state_nx    = HIGH;
                    frame_start = 1'b1;
                end
            end

            HIGH: begin
                if (timed_out) begin
                    state_nx     = SEEK;
                    no_signal_nx = 1'b1;
                    div_abort    = 1'b1;
                end else if (fall) begin
                    state_nx  = LOW;
                    div_start = 1'b1;
                end
            end

            LOW: begin
                if (timed_out) begin
                    state_nx     = SEEK;
                    no_signal_nx = 1'b1;
                    div_abort    = 1'b1;
                end else if (rise) begin
                    state_nx    = HIGH;
                    frame_start = 1'b1;
                    if (period_ok && div_done) begin
                        duty_nx      = clamp_duty(32'(quotient));
                        valid_nx     = 1'b1;
                        no_signal_nx = 1'b0;
                    end else begin
                        // Bad period or a glitch rise before the divider finished
                        period_err_nx = 1'b1;
                        div_abort     = div_busy;
                    end
                end
            end

            default: begin
                state_nx = SEEK;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture, run with the timing constants scaled down by 1000.
module tb_pwm_capture;

    localparam int WIN = 2000;
    localparam int OFS = 50;
    localparam int STP = 2;
    localparam int TOL = 20;
    localparam int TMO = 4000;
    localparam int CW  = 12;
    localparam int NROWS = 18;

    typedef struct {
        int h;
        int p;
        bit ev;
        bit ep;
        int ed;
        bit ens;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       pwm_in;
    logic [6:0] duty_cycle;
    logic       valid;
    logic       period_err;
    logic       no_signal;

    int total = 0;
    int bad   = 0;
    int mon_valid = 0;
    int mon_perr  = 0;
    int mon_both  = 0;
    int exp_nvalid = 0;
    int exp_nperr  = 0;

    // reference model state: last pulse seen and what the receiver should report
    bit m_armed  = 1'b0;
    int m_prev_h = 0;
    int m_prev_p = 0;
    int m_duty   = 0;
    bit m_nosig  = 1'b1;

    vec_t tbl [NROWS];

    pwm_capture #(
        .WINDOW  (WIN),
        .OFFSET  (OFS),
        .STEP    (STP),
        .PER_TOL (TOL),
        .TIMEOUT (TMO),
        .CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pwm_in     (pwm_in),
        .duty_cycle (duty_cycle),
        .valid      (valid),
        .period_err (period_err),
        .no_signal  (no_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) mon_valid++;
        if (period_err === 1'b1) mon_perr++;
        if (valid === 1'b1 && period_err === 1'b1) mon_both++;
    end

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    function automatic int code_of(input int h);
        int q;
        if (h < OFS) return 0;
        q = (h - OFS + STP / 2) / STP;
        return (q > 99) ? 99 : q;
    endfunction

    // Outcome of a rising edge: closes the previous pulse if one is open
    task automatic model_rise(output bit ev, output bit ep);
        int dev;
        ev = 1'b0;
        ep = 1'b0;
        if (m_armed) begin
            dev = m_prev_p - WIN;
            if (dev < 0) dev = -dev;
            if (dev <= TOL && (m_prev_p - m_prev_h) >= CW + 2) begin
                ev      = 1'b1;
                m_duty  = code_of(m_prev_h);
                m_nosig = 1'b0;
            end else begin
                ep = 1'b1;
            end
        end
    endtask

    // One pulse: high h cycles, period p; outputs checked 3 cycles after the rise
    task automatic run_frame(input int h, input int p, input bit ev, input bit ep,
                             input int ed, input bit ens, input string tag);
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        chk({tag, " valid"}, int'(valid), int'(ev));
        chk({tag, " period_err"}, int'(period_err), int'(ep));
        chk({tag, " duty_cycle"}, int'(duty_cycle), ed);
        chk({tag, " no_signal"}, int'(no_signal), int'(ens));
        @(negedge clk);
        chk({tag, " pulse_end"}, int'(valid | period_err), 0);
        repeat (h - 4) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
        if (ev) exp_nvalid++;
        if (ep) exp_nperr++;
        m_duty   = ed;
        m_nosig  = ens;
        m_prev_h = h;
        m_prev_p = p;
        m_armed  = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " duty_cycle"}, int'(duty_cycle), 0);
        chk({tag, " valid"}, int'(valid), 0);
        chk({tag, " period_err"}, int'(period_err), 0);
        chk({tag, " no_signal"}, int'(no_signal), 1);
    endtask

    initial begin
        bit ev;
        bit ep;
        int h;
        int p;

        reset  = 1'b1;
        pwm_in = 1'b0;

        //            high  period valid perr duty nosig   (outcome seen at this rise)
        tbl[0]  = '{  50, 2000, 1'b0, 1'b0,  0, 1'b1};
        tbl[1]  = '{  50, 2000, 1'b1, 1'b0,  0, 1'b0};
        tbl[2]  = '{ 248, 2000, 1'b1, 1'b0,  0, 1'b0};
        tbl[3]  = '{ 130, 2000, 1'b1, 1'b0, 99, 1'b0};
        tbl[4]  = '{  49, 2000, 1'b1, 1'b0, 40, 1'b0};
        tbl[5]  = '{ 300, 2000, 1'b1, 1'b0,  0, 1'b0};
        tbl[6]  = '{  51, 2000, 1'b1, 1'b0, 99, 1'b0};
        tbl[7]  = '{  60, 1000, 1'b1, 1'b0,  1, 1'b0};
        tbl[8]  = '{  60, 2000, 1'b0, 1'b1,  1, 1'b0};
        tbl[9]  = '{ 130, 2000, 1'b1, 1'b0,  5, 1'b0};
        tbl[10] = '{ 130, 2020, 1'b1, 1'b0, 40, 1'b0};
        tbl[11] = '{ 248, 1980, 1'b1, 1'b0, 40, 1'b0};
        tbl[12] = '{  50, 2021, 1'b1, 1'b0, 99, 1'b0};
        tbl[13] = '{  52, 1979, 1'b0, 1'b1, 99, 1'b0};
        tbl[14] = '{  52, 2000, 1'b0, 1'b1, 99, 1'b0};
        tbl[15] = '{  60,   65, 1'b1, 1'b0,  1, 1'b0};
        tbl[16] = '{  90, 2000, 1'b0, 1'b1,  1, 1'b0};
        tbl[17] = '{ 130, 2000, 1'b1, 1'b0, 20, 1'b0};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < NROWS; i++) begin
            run_frame(tbl[i].h, tbl[i].p, tbl[i].ev, tbl[i].ep, tbl[i].ed, tbl[i].ens,
                      $sformatf("row%0d", i));
        end

        // input stuck low: last rise was 2000 cycles ago
        repeat (1990) @(negedge clk);
        chk("pre_timeout no_signal", int'(no_signal), 0);
        repeat (20) @(negedge clk);
        chk("timeout no_signal", int'(no_signal), 1);
        chk("timeout duty_hold", int'(duty_cycle), 20);
        m_armed = 1'b0;
        m_nosig = 1'b1;

        // resume: first rise only opens a frame, second reports it
        run_frame(130, 2000, 1'b0, 1'b0, 20, 1'b1, "resume1");
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("resume2 valid", int'(valid), 1);
        chk("resume2 duty_cycle", int'(duty_cycle), 40);
        chk("resume2 no_signal", int'(no_signal), 0);
        exp_nvalid++;

        // reset in the middle of the high phase
        repeat (17) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        pwm_in = 1'b0;
        repeat (1500) @(negedge clk);
        m_armed = 1'b0;
        m_duty  = 0;
        m_nosig = 1'b1;
        run_frame(248, 2000, 1'b0, 1'b0,  0, 1'b1, "post_rst1");
        run_frame(130, 2000, 1'b1, 1'b0, 99, 1'b0, "post_rst2");

        // random pulses against the reference model
        for (int i = 0; i < 9; i++) begin
            h = int'($urandom_range(320, 10));
            p = int'($urandom_range(2050, 1950));
            model_rise(ev, ep);
            run_frame(h, p, ev, ep, m_duty, m_nosig, $sformatf("rnd%0d", i));
        end

        repeat (5) @(negedge clk);
        chk("valid_count", mon_valid, exp_nvalid);
        chk("period_err_count", mon_perr, exp_nperr);
        chk("valid_and_err_overlap", mon_both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
